mux4_rr_arbiter: RTL and testbench

Round-robin arbiter and select sequencer for the shared 4-to-1 NOR-gate mux datapath. Four requesters compete for the single mux output. The block grants one at a time, drives the mux select lines `s1`/`s0`, and counts accepted beats on the output handshake. It releases the grant after a fixed burst length or when the owner withdraws its request.

---
 rtl/mux4_rr_arbiter.sv | 94 +++++++++
 tb/tb_mux4_rr_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter and select sequencer for the shared 4-to-1 mux datapath.
// Grants one requester at a time for up to BURST_LEN accepted beats.
module mux4_rr_arbiter #(
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       out_ready,
  output logic [3:0] gnt,
  output logic       s0,
  output logic       s1,
  output logic       out_valid,
  output logic [3:0] ack,
  output logic       busy
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  logic [1:0]       ptr;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       owner;
  logic             owner_req;
  logic             last_beat;
  logic [1:0]       win_idx;
  logic             win_any;

  // The select lines double as the owner index while BUSY
  assign owner     = {s1, s0};
  assign owner_req = req[owner];
  assign busy      = (state == BUSY);
  assign last_beat = (cnt == CNT_W'(BURST_LEN - 1));
  assign out_valid = busy & owner_req;
  assign ack       = gnt & req & {4{out_ready}};

  always_comb begin
    logic [1:0] cand;
    win_idx = ptr;
    win_any = 1'b0;
    cand    = ptr;
    // Scan from lowest to highest priority so the highest-priority hit is kept
    for (int k = 3; k >= 0; k--) begin
      cand = ptr + 2'(k);
      if (req[cand]) begin
        win_idx = cand;
        win_any = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt   <= '0;
      s0    <= 1'b0;
      s1    <= 1'b0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_any) begin
            state    <= BUSY;
            gnt      <= 4'b0001 << win_idx;
            {s1, s0} <= win_idx;
            cnt      <= '0;
            ptr      <= win_idx + 2'd1;
          end
        end
        BUSY: begin
          // Selects are left alone on release so the mux never points elsewhere
          if (!owner_req) begin
            state <= IDLE;
            gnt   <= '0;
          end else if (out_ready) begin
            if (last_beat) begin
              state <= IDLE;
              gnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboard bench for mux4_rr_arbiter: directed vectors push expected acks,
// a negedge monitor pops them whenever an instance presents an ack.
module tb_mux4_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req_a, req_b;
  logic       rdy_a, rdy_b;
  logic [3:0] gnt_a, gnt_b, ack_a, ack_b;
  logic       s0_a, s1_a, s0_b, s1_b;
  logic       out_valid_a, out_valid_b, busy_a, busy_b;

  int         checks   = 0;
  int         failures = 0;
  logic [5:0] q_a[$];
  logic [5:0] q_b[$];
  logic [5:0] e_a, e_b;
  logic [1:0] last_sel_a, last_sel_b;
  logic [3:0] oh;
  logic       rdy_pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  always #5 clk = ~clk;

  mux4_rr_arbiter #(.BURST_LEN(4), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req_a), .out_ready(rdy_a), .gnt(gnt_a),
    .s0(s0_a), .s1(s1_a), .out_valid(out_valid_a), .ack(ack_a), .busy(busy_a)
  );

  mux4_rr_arbiter #(.BURST_LEN(1), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .out_ready(rdy_b), .gnt(gnt_b),
    .s0(s0_b), .s1(s1_b), .out_valid(out_valid_b), .ack(ack_b), .busy(busy_b)
  );

  function automatic logic [1:0] idx_of(input logic [3:0] v);
    case (v)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive inputs, queue the expected ack, check grant/select state
  task automatic applyStimulus(input bit inst_b, input logic [3:0] r, input logic rdy,
                               input logic [3:0] exp_gnt, input logic [3:0] exp_ack);
    logic [1:0] exp_sel;
    if (!inst_b) begin
      req_a = r;
      rdy_a = rdy;
      if (exp_ack != 4'b0) q_a.push_back({idx_of(exp_ack), exp_ack});
      if (exp_gnt != 4'b0) last_sel_a = idx_of(exp_gnt);
      exp_sel = last_sel_a;
    end else begin
      req_b = r;
      rdy_b = rdy;
      if (exp_ack != 4'b0) q_b.push_back({idx_of(exp_ack), exp_ack});
      if (exp_gnt != 4'b0) last_sel_b = idx_of(exp_gnt);
      exp_sel = last_sel_b;
    end
    @(negedge clk);
    if (!inst_b) begin
      checkOutput("gnt_a", {4'b0, gnt_a}, {4'b0, exp_gnt});
      checkOutput("busy_a", {7'b0, busy_a}, {7'b0, |exp_gnt});
      checkOutput("sel_a", {6'b0, s1_a, s0_a}, {6'b0, exp_sel});
    end else begin
      checkOutput("gnt_b", {4'b0, gnt_b}, {4'b0, exp_gnt});
      checkOutput("busy_b", {7'b0, busy_b}, {7'b0, |exp_gnt});
      checkOutput("sel_b", {6'b0, s1_b, s0_b}, {6'b0, exp_sel});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulseReset();
    rst_n      = 1'b0;
    last_sel_a = 2'd0;
    last_sel_b = 2'd0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (ack_a != 4'b0) begin
      if (q_a.size() == 0) checkOutput("ack_a_unexpected", {4'b0, ack_a}, 8'h00);
      else begin
        e_a = q_a.pop_front();
        checkOutput("ack_a", {2'b0, s1_a, s0_a, ack_a}, {2'b0, e_a});
      end
    end
    if (ack_b != 4'b0) begin
      if (q_b.size() == 0) checkOutput("ack_b_unexpected", {4'b0, ack_b}, 8'h00);
      else begin
        e_b = q_b.pop_front();
        checkOutput("ack_b", {2'b0, s1_b, s0_b, ack_b}, {2'b0, e_b});
      end
    end
  end

  initial begin
    rst_n = 1'b0; req_a = 4'b0; req_b = 4'b0; rdy_a = 1'b0; rdy_b = 1'b0;
    last_sel_a = 2'd0; last_sel_b = 2'd0;
    repeat (2) @(posedge clk);
    req_a = 4'b1111; rdy_a = 1'b1;
    #1;
    checkOutput("rst_gnt", {4'b0, gnt_a}, 8'h00);
    checkOutput("rst_busy", {7'b0, busy_a}, 8'h00);
    checkOutput("rst_sel", {6'b0, s1_a, s0_a}, 8'h00);
    checkOutput("rst_valid", {7'b0, out_valid_a}, 8'h00);
    checkOutput("rst_ack", {4'b0, ack_a}, 8'h00);
    req_a = 4'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("[TB] single requester 2");
    applyStimulus(0, 4'b0100, 1'b1, 4'b0000, 4'b0000);
    repeat (4) applyStimulus(0, 4'b0100, 1'b1, 4'b0100, 4'b0100);
    applyStimulus(0, 4'b0100, 1'b1, 4'b0000, 4'b0000);
    applyStimulus(0, 4'b0000, 1'b1, 4'b0100, 4'b0000);
    applyStimulus(0, 4'b0000, 1'b1, 4'b0000, 4'b0000);

    $display("[TB] all four requesting");
    pulseReset();
    for (int g = 0; g < 5; g++) begin
      oh = 4'b0001 << (g % 4);
      applyStimulus(0, 4'b1111, 1'b1, 4'b0000, 4'b0000);
      repeat (4) applyStimulus(0, 4'b1111, 1'b1, oh, oh);
    end
    applyStimulus(0, 4'b0000, 1'b1, 4'b0000, 4'b0000);

    $display("[TB] stall on owner 1");
    applyStimulus(0, 4'b0010, 1'b1, 4'b0000, 4'b0000);
    for (int i = 0; i < 7; i++)
      applyStimulus(0, 4'b0010, rdy_pat[i], 4'b0010, rdy_pat[i] ? 4'b0010 : 4'b0000);
    applyStimulus(0, 4'b0000, 1'b1, 4'b0000, 4'b0000);

    $display("[TB] owner 3 abandons");
    applyStimulus(0, 4'b1001, 1'b1, 4'b0000, 4'b0000);
    repeat (2) applyStimulus(0, 4'b1001, 1'b1, 4'b1000, 4'b1000);
    applyStimulus(0, 4'b0001, 1'b1, 4'b1000, 4'b0000);
    applyStimulus(0, 4'b0001, 1'b1, 4'b0000, 4'b0000);
    repeat (4) applyStimulus(0, 4'b0001, 1'b1, 4'b0001, 4'b0001);
    applyStimulus(0, 4'b0000, 1'b1, 4'b0000, 4'b0000);

    $display("[TB] reset mid-burst");
    applyStimulus(0, 4'b0100, 1'b1, 4'b0000, 4'b0000);
    applyStimulus(0, 4'b0100, 1'b1, 4'b0100, 4'b0100);
    req_a = 4'b0100; rdy_a = 1'b1; rst_n = 1'b0;
    last_sel_a = 2'd0; last_sel_b = 2'd0;
    #1;
    checkOutput("midrst_gnt", {4'b0, gnt_a}, 8'h00);
    checkOutput("midrst_busy", {7'b0, busy_a}, 8'h00);
    checkOutput("midrst_sel", {6'b0, s1_a, s0_a}, 8'h00);
    checkOutput("midrst_ack", {4'b0, ack_a}, 8'h00);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    req_a = 4'b1111; rst_n = 1'b1;
    applyStimulus(0, 4'b1111, 1'b1, 4'b0000, 4'b0000);
    applyStimulus(0, 4'b1111, 1'b1, 4'b0001, 4'b0001);
    applyStimulus(0, 4'b0000, 1'b1, 4'b0001, 4'b0000);
    applyStimulus(0, 4'b0000, 1'b1, 4'b0000, 4'b0000);

    $display("[TB] BURST_LEN=1 alternation");
    applyStimulus(1, 4'b0011, 1'b1, 4'b0000, 4'b0000);
    for (int i = 0; i < 4; i++) begin
      oh = (i % 2 == 1) ? 4'b0010 : 4'b0001;
      applyStimulus(1, 4'b0011, 1'b1, oh, oh);
      applyStimulus(1, (i == 3) ? 4'b0000 : 4'b0011, 1'b1, 4'b0000, 4'b0000);
    end

    @(negedge clk);
    checkOutput("q_a_drained", 8'(q_a.size()), 8'h00);
    checkOutput("q_b_drained", 8'(q_b.size()), 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
